// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Purpose  : LoongArch32 instruction encoder. Range-checks an immediate or
//            byte offset, packs it into the architectural field layout
//            (si12, ui12, ui5, si20, offs26) and emits one or two 32-bit
//            instruction words over a valid/ready stream.
// Macro    : ENC_LI_EN - when defined, op 7 (LI pseudo-op) expands to
//            ORI or LU12I.W + ORI. When undefined, op 7 is rejected, the HI
//            state and ORI holding register are not built, and out_last
//            follows out_valid.
// Ports    :
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted on req_valid & req_ready
//   req_op     in   [2:0] 0 ADDI.W 1 ORI 2 SLLI.W 3 LU12I.W 4 LD.W 5 ST.W
//                         6 B 7 LI
//   req_rd     in   [4:0] rd (store data register for ST.W)
//   req_rj     in   [4:0] rj (ignored for LU12I.W, B, LI)
//   req_imm    in   [31:0] immediate, or signed byte offset for B
//   out_valid  out  out_inst valid
//   out_ready  in   sink accepts on out_valid & out_ready
//   out_inst   out  [31:0] encoded word
//   out_last   out  final word of the current request
//   err        out  one-cycle pulse, request rejected
//   word_cnt   out  [15:0] words handed off, wraps
// Revision : 1.0 - initial release
// ============================================================================
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rj,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        err,
  output logic [15:0] word_cnt
);

  // Operation codes on req_op
  localparam logic [2:0] OP_ADDI  = 3'd0;
  localparam logic [2:0] OP_ORI   = 3'd1;
  localparam logic [2:0] OP_SLLI  = 3'd2;
  localparam logic [2:0] OP_LU12I = 3'd3;
  localparam logic [2:0] OP_LDW   = 3'd4;
  localparam logic [2:0] OP_STW   = 3'd5;
  localparam logic [2:0] OP_B     = 3'd6;
  localparam logic [2:0] OP_LI    = 3'd7;

  // Fixed opcode bits of each instruction format
  localparam logic [31:0] BASE_ADDI  = 32'h0280_0000;
  localparam logic [31:0] BASE_ORI   = 32'h0380_0000;
  localparam logic [31:0] BASE_SLLI  = 32'h0040_8000;
  localparam logic [31:0] BASE_LU12I = 32'h1400_0000;
  localparam logic [31:0] BASE_LDW   = 32'h2880_0000;
  localparam logic [31:0] BASE_STW   = 32'h2980_0000;
  localparam logic [31:0] BASE_B     = 32'h5000_0000;

`ifdef ENC_LI_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_HI   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        err_q, err_d;
  logic [15:0] word_cnt_q, word_cnt_d;
`ifdef ENC_LI_EN
  logic        out_last_q, out_last_d;
  logic [31:0] hold_q, hold_d;     // ORI word of an LI waiting behind LU12I.W
`endif

  // --------------------------------------------------------------------------
  // Immediate range checks
  // --------------------------------------------------------------------------
  logic si12_ok, ui12_ok, ui5_ok, si20_ok, offs_ok;

  // Signed fields are legal when every bit above the field's sign bit
  // replicates it, i.e. the upper slice is all ones or all zeros.
  assign si12_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign ui12_ok = ~(|req_imm[31:12]);
  assign ui5_ok  = ~(|req_imm[31:5]);
  assign si20_ok = (&req_imm[31:19]) | ~(|req_imm[31:19]);
  assign offs_ok = (req_imm[1:0] == 2'b00) &
                   ((&req_imm[31:27]) | ~(|req_imm[31:27]));

  // --------------------------------------------------------------------------
  // Field packing
  // --------------------------------------------------------------------------
  logic        enc_legal;
  logic [31:0] enc_word0;
`ifdef ENC_LI_EN
  logic        enc_two;
  logic [31:0] enc_word1;
`endif

  always_comb begin
    enc_legal = 1'b0;
    enc_word0 = 32'h0;
`ifdef ENC_LI_EN
    enc_two   = 1'b0;
    enc_word1 = 32'h0;
`endif
    case (req_op)
      OP_ADDI: begin
        enc_legal = si12_ok;
        enc_word0 = BASE_ADDI | {10'd0, req_imm[11:0], req_rj, req_rd};
      end
      OP_ORI: begin
        enc_legal = ui12_ok;
        enc_word0 = BASE_ORI | {10'd0, req_imm[11:0], req_rj, req_rd};
      end
      OP_SLLI: begin
        enc_legal = ui5_ok;
        enc_word0 = BASE_SLLI | {17'd0, req_imm[4:0], req_rj, req_rd};
      end
      OP_LU12I: begin
        enc_legal = si20_ok;
        enc_word0 = BASE_LU12I | {7'd0, req_imm[19:0], req_rd};
      end
      OP_LDW: begin
        enc_legal = si12_ok;
        enc_word0 = BASE_LDW | {10'd0, req_imm[11:0], req_rj, req_rd};
      end
      OP_STW: begin
        enc_legal = si12_ok;
        enc_word0 = BASE_STW | {10'd0, req_imm[11:0], req_rj, req_rd};
      end
      OP_B: begin
        // offs = imm[27:2]; offs[15:0] lands at [25:10], offs[25:16] at [9:0]
        enc_legal = offs_ok;
        enc_word0 = BASE_B | {6'd0, req_imm[17:2], req_imm[27:18]};
      end
      OP_LI: begin
`ifdef ENC_LI_EN
        // Any 32-bit value is reachable, so LI is never rejected.
        enc_legal = 1'b1;
        if (~(|req_imm[31:12])) begin
          // Small value: a single ORI rd, r0, imm
          enc_word0 = BASE_ORI | {10'd0, req_imm[11:0], 5'd0, req_rd};
        end else begin
          enc_two   = 1'b1;
          enc_word0 = BASE_LU12I | {7'd0, req_imm[31:12], req_rd};
          enc_word1 = BASE_ORI | {10'd0, req_imm[11:0], req_rd, req_rd};
        end
`else
        enc_legal = 1'b0;
`endif
      end
      default: begin
        enc_legal = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic accept;
  logic handoff;

  // rst_n gates req_ready so nothing is accepted while reset is held.
  assign req_ready = rst_n & ((state_q == S_IDLE) |
                              ((state_q == S_ONE) & out_ready));
  assign out_valid = (state_q != S_IDLE);
  assign accept    = req_valid & req_ready;
  assign handoff   = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    out_inst_d = out_inst_q;
`ifdef ENC_LI_EN
    out_last_d = out_last_q;
    hold_d     = hold_q;
`endif
    err_d      = accept & ~enc_legal;
    word_cnt_d = word_cnt_q + {15'd0, handoff};

    // Retire the held word first; a same-cycle accept below overrides it.
    if (handoff) begin
`ifdef ENC_LI_EN
      if (state_q == S_HI) begin
        state_d    = S_ONE;
        out_inst_d = hold_q;
        out_last_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
`else
      state_d = S_IDLE;
`endif
    end

    // req_ready is 0 in HI, so an accept never collides with the HI->ONE
    // transfer of the ORI word.
    if (accept && enc_legal) begin
`ifdef ENC_LI_EN
      if (enc_two) begin
        state_d    = S_HI;
        out_inst_d = enc_word0;
        out_last_d = 1'b0;
        hold_d     = enc_word1;
      end else begin
        state_d    = S_ONE;
        out_inst_d = enc_word0;
        out_last_d = 1'b1;
      end
`else
      state_d    = S_ONE;
      out_inst_d = enc_word0;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      out_inst_q <= 32'h0;
      err_q      <= 1'b0;
      word_cnt_q <= 16'h0;
`ifdef ENC_LI_EN
      out_last_q <= 1'b0;
      hold_q     <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      out_inst_q <= out_inst_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
`ifdef ENC_LI_EN
      out_last_q <= out_last_d;
      hold_q     <= hold_d;
`endif
    end
  end

  assign out_inst = out_inst_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;
`ifdef ENC_LI_EN
  assign out_last = out_last_q;
`else
  // Every request is a single word, so any valid word is the last one.
  assign out_last = out_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_encoder
// Purpose  : Self-checking bench for inst_encoder. A table of single-word
//            requests with hand-computed encodings is applied in a loop,
//            followed by hand-written sequences for back-pressure, LI
//            expansion and reset in the middle of a pending request.
//            LI expectations follow ENC_LI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rj;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        err;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rj    (req_rj),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [31:0] imm;
    logic        exp_err;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] rd,
                              input logic [4:0] rj, input logic [31:0] imm,
                              input logic e, input logic [31:0] inst);
    vec_t v;
    v.op = op; v.rd = rd; v.rj = rj; v.imm = imm;
    v.exp_err = e; v.exp_inst = inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1;
    req_op    = v.op;
    req_rd    = v.rd;
    req_rj    = v.rj;
    req_imm   = v.imm;
  endtask

  task automatic drop_req();
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_rd    = 5'd0;
    req_rj    = 5'd0;
    req_imm   = 32'h0;
  endtask

  // Safety net: the bench is fixed-length, this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    vec_t li_big;
    vec_t li_small;
    vec_t rst_v;
    logic li_err;

`ifdef ENC_LI_EN
    li_err = 1'b0;
`else
    li_err = 1'b1;
`endif

    // op, rd, rj, imm, expect err, expected word
    vecs.push_back(mk(3'd0, 5'd1,  5'd2,  32'hFFFF_FFFF, 1'b0, 32'h02BF_FC41));
    vecs.push_back(mk(3'd0, 5'd1,  5'd2,  32'd2048,      1'b1, 32'h0));
    vecs.push_back(mk(3'd0, 5'd5,  5'd6,  32'hFFFF_F800, 1'b0, 32'h02A0_00C5));
    vecs.push_back(mk(3'd1, 5'd7,  5'd8,  32'h0000_0FFF, 1'b0, 32'h03BF_FD07));
    vecs.push_back(mk(3'd1, 5'd7,  5'd8,  32'h0000_1000, 1'b1, 32'h0));
    vecs.push_back(mk(3'd2, 5'd3,  5'd3,  32'd31,        1'b0, 32'h0040_FC63));
    vecs.push_back(mk(3'd2, 5'd3,  5'd3,  32'd32,        1'b1, 32'h0));
    vecs.push_back(mk(3'd3, 5'd9,  5'd31, 32'h0007_FFFF, 1'b0, 32'h14FF_FFE9));
    vecs.push_back(mk(3'd3, 5'd9,  5'd0,  32'h0008_0000, 1'b1, 32'h0));
    vecs.push_back(mk(3'd4, 5'd10, 5'd11, 32'd4,         1'b0, 32'h2880_116A));
    vecs.push_back(mk(3'd5, 5'd12, 5'd13, 32'hFFFF_FFFC, 1'b0, 32'h29BF_F1AC));
    vecs.push_back(mk(3'd6, 5'd0,  5'd0,  32'hFFFF_FFFC, 1'b0, 32'h53FF_FFFF));
    vecs.push_back(mk(3'd6, 5'd0,  5'd0,  32'd6,         1'b1, 32'h0));
    vecs.push_back(mk(3'd6, 5'd0,  5'd0,  32'h0800_0000, 1'b1, 32'h0));
    vecs.push_back(mk(3'd6, 5'd1,  5'd2,  32'h07FF_FFFC, 1'b0, 32'h53FF_FDFF));
    vecs.push_back(mk(3'd6, 5'd0,  5'd0,  32'd8,         1'b0, 32'h5000_0800));
    vecs.push_back(mk(3'd7, 5'd5,  5'd9,  32'h0000_0ABC, li_err,
                      li_err ? 32'h0 : 32'h03AA_F005));

    li_big   = mk(3'd7, 5'd4, 5'd9, 32'h1234_5678, li_err, 32'h142468A4);
    li_small = mk(3'd2, 5'd3, 5'd3, 32'd31, 1'b0, 32'h0040_FC63);

    // ---------------- reset ----------------
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drop_req();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst",  out_inst, 32'h0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    chk("rst_err",       {31'd0, err}, 32'd0);
    chk("rst_word_cnt",  {16'd0, word_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    exp_cnt = 16'd0;

    // ---------------- table of single requests ----------------
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v);
      #1 chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      drop_req();
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, ~v.exp_err});
      if (!v.exp_err) begin
        chk($sformatf("v%0d_inst", i), out_inst, v.exp_inst);
        chk($sformatf("v%0d_last", i), {31'd0, out_last}, 32'd1);
        exp_cnt++;
      end
      @(negedge clk);
      chk($sformatf("v%0d_err_clr", i), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d_idle", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_cnt", i), {16'd0, word_cnt}, {16'd0, exp_cnt});
    end

    // ---------------- back-pressure on SLLI ----------------
    out_ready = 1'b0;
    drive(li_small);
    @(negedge clk);
    drop_req();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_inst", k), out_inst, 32'h0040_FC63);
      chk($sformatf("stall%0d_ready", k), {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("stall_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    out_ready = 1'b1;
    drive(vecs[0]);
    #1 chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    drop_req();
    exp_cnt++;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_inst", out_inst, 32'h02BF_FC41);
    chk("b2b_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    @(negedge clk);
    exp_cnt++;
    chk("b2b_idle", {31'd0, out_valid}, 32'd0);
    chk("b2b_cnt2", {16'd0, word_cnt}, {16'd0, exp_cnt});

    // ---------------- LI r4, 0x12345678 ----------------
    drive(li_big);
    @(negedge clk);
    drop_req();
    if (!li_err) begin
      chk("li_hi_valid", {31'd0, out_valid}, 32'd1);
      chk("li_hi_inst", out_inst, 32'h1424_68A4);
      chk("li_hi_last", {31'd0, out_last}, 32'd0);
      chk("li_hi_ready", {31'd0, req_ready}, 32'd0);
      chk("li_hi_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      exp_cnt++;
      chk("li_lo_valid", {31'd0, out_valid}, 32'd1);
      chk("li_lo_inst", out_inst, 32'h0399_E084);
      chk("li_lo_last", {31'd0, out_last}, 32'd1);
      chk("li_lo_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
      @(negedge clk);
      exp_cnt++;
    end else begin
      chk("li_err", {31'd0, err}, 32'd1);
      chk("li_err_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("li_err_clr", {31'd0, err}, 32'd0);
    end
    chk("li_idle", {31'd0, out_valid}, 32'd0);
    chk("li_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});

    // ---------------- reset with a word pending ----------------
    // With LI built the reset hits the HI state; otherwise a stalled SLLI.
    rst_v = li_err ? li_small : li_big;
    out_ready = 1'b0;
    drive(rst_v);
    @(negedge clk);
    drop_req();
    chk("pend_valid", {31'd0, out_valid}, 32'd1);
    chk("pend_last", {31'd0, out_last}, {31'd0, li_err});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inst", out_inst, 32'h0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_cnt", {16'd0, word_cnt}, 32'd0);
    exp_cnt = 16'd0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_valid", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("post_rst%0d_cnt", k), {16'd0, word_cnt}, 32'd0);
    end
    drive(vecs[0]);
    #1 chk("restart_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    drop_req();
    chk("restart_inst", out_inst, 32'h02BF_FC41);
    chk("restart_last", {31'd0, out_last}, 32'd1);
    @(negedge clk);
    exp_cnt++;
    chk("restart_cnt", {16'd0, word_cnt}, {16'd0, exp_cnt});
    chk("restart_idle", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
# inst_encoder

LoongArch32 instruction encoder: the write side of the immediate/offset field decoder in the decode stage. It accepts an encode request (operation class, register numbers, 32-bit immediate or byte offset), range-checks the immediate, and packs it into the architectural field layout (si12, ui12, ui5, si20, offs26). It emits one or two 32-bit instruction words over a valid/ready stream. Used by the debug instruction injector and by the decoder round-trip self-test.

## Interface
- No parameters. Word width fixed at 32.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on `req_valid & req_ready`.
- `req_op` in 3: 0 ADDI.W, 1 ORI, 2 SLLI.W, 3 LU12I.W, 4 LD.W, 5 ST.W, 6 B, 7 LI (pseudo-op).
- `req_rd` in 5: rd field; for ST.W this is the store data register.
- `req_rj` in 5: rj field; ignored for LU12I.W, B, LI.
- `req_imm` in 32: immediate, or signed byte offset for B.
- `out_valid` out 1: `out_inst` valid.
- `out_ready` in 1: sink accepts on `out_valid & out_ready`.
- `out_inst` out 32: encoded word.
- `out_last` out 1: final word of the current request.
- `err` out 1: one-cycle pulse; request rejected.
- `word_cnt` out 16: count of words handed off, wraps at 0xFFFF->0.

## Operation
- Field packing: rd at [4:0], rj at [9:5].
  - ADDI.W: 0x02800000 | si12 at [21:10].
  - ORI: 0x03800000 | ui12 at [21:10].
  - SLLI.W: 0x00408000 | ui5 at [14:10].
  - LU12I.W: 0x14000000 | si20 at [24:5].
  - LD.W: 0x28800000 | si12 at [21:10].
  - ST.W: 0x29800000 | si12 at [21:10].
  - B: 0x50000000 | offs[15:0] at [25:10] | offs[25:16] at [9:0], where offs = imm[27:2].
- Range checks, failure means illegal:
  - si12: imm[31:11] all equal.
  - ui12: imm[31:12] == 0.
  - ui5: imm[31:5] == 0.
  - si20: imm[31:19] all equal.
  - B: imm[1:0] == 0 and imm[31:27] all equal.
- LI rd, imm:
  - If imm[31:12] == 0: emit one word, ORI rd, r0, imm[11:0].
  - Otherwise emit two words: LU12I.W rd, imm[31:12], then ORI rd, rd, imm[11:0].
- Illegal request:
  - Accepted normally (handshake completes).
  - `err` pulses high the following cycle.
  - No word is emitted and `word_cnt` is unchanged.
- FSM states:
  - IDLE: `out_valid` = 0.
  - ONE: single or final word held.
  - HI: first LI word held; ORI word stored in an internal register.
  - ONE -> IDLE on handoff with no new request; ONE -> ONE on handoff with a simultaneous legal single-word request.
  - HI -> ONE on handoff (ORI word loaded, `out_last` = 1).
  - Any state -> IDLE on `rst_n` low.
- `req_ready` = (state == IDLE) | (state == ONE & out_ready). It is 0 in HI.
- `word_cnt` increments on every `out_valid & out_ready`.

## Timing
- Reset values: `req_ready` 0 while `rst_n` is low, then 1 in IDLE; `out_valid` 0, `out_inst` 0, `out_last` 0, `err` 0, `word_cnt` 0. State is IDLE.
- Latency: request accepted at edge N -> `out_valid` (or `err`) high after edge N, i.e. during cycle N+1.
- Throughput: one word per cycle for back-to-back single-word requests; LI (two words) takes 2 cycles minimum.
- `out_inst` and `out_last` are registered and stay stable while `out_valid & ~out_ready`.
- `err` and an emitted word never coincide for the same request. An `err` pulse may overlap handoff of the previous request's word.
- Reset asserted mid-LI (in HI) discards the pending ORI word; after reset the stream restarts clean.

## Configuration
- `ENC_LI_EN` defined: op 7 (LI) is supported as described above.
- `ENC_LI_EN` undefined:
  - Op 7 is illegal and returns an `err` pulse.
  - The HI state and the ORI holding register are not built.
  - `out_last` is tied to 1 whenever `out_valid` is 1.

## Test plan
- ADDI r1, r2, imm=0xFFFFFFFF -> one word 0x02BFFC41 with `out_last` = 1; `word_cnt` goes 0 -> 1.
- ADDI with imm=2048 -> `err` pulses for one cycle, `out_valid` stays 0, `word_cnt` unchanged.
- LI r4, 0x12345678 with `ENC_LI_EN` defined -> 0x142468A4 (`out_last` = 0), then 0x0399E084 (`out_last` = 1); `req_ready` is 0 between the two words. Same request with `ENC_LI_EN` undefined -> `err` pulse, no words.
- B with imm=-4 -> 0x53FFFFFF. B with imm=6 -> `err` (misaligned).
- SLLI r3, r3, 31 -> 0x0040FC63. Hold `out_ready` low for 3 cycles -> `out_inst` stable and `req_ready` = 0 throughout; on release the word is handed off and the next request is accepted in the same cycle.
- Assert `rst_n` low while in HI of LI r4, 0x12345678 -> all outputs return to reset values immediately; the ORI word is never emitted; `word_cnt` = 0.
